// File: rtl/hssdrc_sdram_cmd_pkg.sv
// rtl/hssdrc_sdram_cmd_pkg.sv - SDRAM command encodings shared by core, scheduler and bench
package hssdrc_sdram_cmd_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    typedef logic [3:0] sdram_cmd_t;

    localparam sdram_cmd_t CMD_NOP  = 4'b0111;
    localparam sdram_cmd_t CMD_ACT  = 4'b0011;
    localparam sdram_cmd_t CMD_RD   = 4'b0101;
    localparam sdram_cmd_t CMD_WR   = 4'b0100;
    localparam sdram_cmd_t CMD_BT   = 4'b0110;
    localparam sdram_cmd_t CMD_PRE  = 4'b0010;
    localparam sdram_cmd_t CMD_AREF = 4'b0001;
    localparam sdram_cmd_t CMD_LMR  = 4'b0000;

    localparam int A10_ALL_BANKS = 10;

endpackage

// File: rtl/hssdrc_refr_timer.sv
// rtl/hssdrc_refr_timer.sv - refresh period down-counter with pending and sticky overrun flags
module hssdrc_refr_timer #(
    parameter int pRefrPeriod = 1560
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_clear,
    output logic o_pending,
    output logic o_overrun
);

    logic [15:0] r_cnt;
    logic        r_run;
    logic        r_pending;
    logic        r_overrun;
    logic        w_wrap;

    assign w_wrap = r_run && (r_cnt == '0) && !i_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_run     <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_load) begin
                r_cnt <= 16'(pRefrPeriod - 1);
                r_run <= 1'b1;
            end else if (r_run) begin
                r_cnt <= (r_cnt == '0) ? 16'(pRefrPeriod - 1) : r_cnt - 16'd1;
            end
            // a wrap wins over the clear so a period landing on refresh end is not lost
            if (w_wrap)
                r_pending <= 1'b1;
            else if (i_clear)
                r_pending <= 1'b0;
            if (w_wrap && r_pending && !i_clear)
                r_overrun <= 1'b1;
        end
    end

    assign o_pending = r_pending | w_wrap;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/hssdrc_init_refr_sched.sv
// rtl/hssdrc_init_refr_sched.sv - SDRAM power-up init sequencer and auto-refresh scheduler
module hssdrc_init_refr_sched
    import hssdrc_sdram_cmd_pkg::*;
#(
    parameter int          pInitWait    = 20000,
    parameter int          pTrp         = 3,
    parameter int          pTrfc        = 7,
    parameter int          pTmrd        = 2,
    parameter int          pInitRefrNum = 8,
    parameter int          pRefrPeriod  = 1560,
    parameter logic [11:0] pModeValue   = 12'h022
) (
    input  logic        clk,
    input  logic        reset,
    output logic        init_done,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        bus_own,
    output logic        refr_overrun,
    output logic        cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [1:0]  ba,
    output logic [11:0] a
);

    localparam int          lTrp      = (pTrp  < 1) ? 1 : pTrp;
    localparam int          lTrfc     = (pTrfc < 1) ? 1 : pTrfc;
    localparam int          lTmrd     = (pTmrd < 1) ? 1 : pTmrd;
    localparam logic [11:0] lPreaAddr = 12'(1 << A10_ALL_BANKS);

    typedef enum logic [3:0] {
        INIT_WAIT, I_PREA, I_TRP, I_AREF, I_TRFC, I_LMR, I_TMRD,
        IDLE, REQ, PREA, TRP, AREF, TRFC
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [7:0]  r_arefs, w_arefs_nxt, w_arefs_inc;
    logic        w_timer_load, w_timer_clear, w_pending;

    sdram_cmd_t  r_cmd;
    logic [1:0]  r_ba;
    logic [11:0] r_a;
    logic        r_init_done, r_bus_req, r_bus_own;

    hssdrc_refr_timer #(.pRefrPeriod(pRefrPeriod)) u_refr_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_timer_load),
        .i_clear   (w_timer_clear),
        .o_pending (w_pending),
        .o_overrun (refr_overrun)
    );

    assign w_arefs_inc = r_arefs + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT_WAIT;
            r_cnt   <= 16'(pInitWait - 1);
            r_arefs <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_arefs <= w_arefs_nxt;
        end
    end

    // wait states are entered with lX-2 so that they last lX-1 cycles; lX==1 skips them
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = (r_cnt == '0) ? '0 : r_cnt - 16'd1;
        w_arefs_nxt   = r_arefs;
        w_timer_load  = 1'b0;
        w_timer_clear = 1'b0;
        case (r_state)
            INIT_WAIT: if (r_cnt == '0) w_state_nxt = I_PREA;
            I_PREA, PREA: begin
                if (lTrp > 1) begin
                    w_state_nxt = (r_state == I_PREA) ? I_TRP : TRP;
                    w_cnt_nxt   = 16'(lTrp - 2);
                end else begin
                    w_state_nxt = (r_state == I_PREA) ? I_AREF : AREF;
                end
            end
            I_TRP: if (r_cnt == '0) w_state_nxt = I_AREF;
            TRP:   if (r_cnt == '0) w_state_nxt = AREF;
            I_AREF: begin
                w_arefs_nxt = w_arefs_inc;
                if (lTrfc > 1) begin
                    w_state_nxt = I_TRFC;
                    w_cnt_nxt   = 16'(lTrfc - 2);
                end else begin
                    w_state_nxt = (w_arefs_inc >= 8'(pInitRefrNum)) ? I_LMR : I_AREF;
                end
            end
            I_TRFC: if (r_cnt == '0) w_state_nxt = (r_arefs >= 8'(pInitRefrNum)) ? I_LMR : I_AREF;
            I_LMR: begin
                if (lTmrd > 1) begin
                    w_state_nxt = I_TMRD;
                    w_cnt_nxt   = 16'(lTmrd - 2);
                end else begin
                    w_state_nxt  = IDLE;
                    w_timer_load = 1'b1;
                end
            end
            I_TMRD: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = IDLE;
                    w_timer_load = 1'b1;
                end
            end
            IDLE: if (w_pending) w_state_nxt = REQ;
            REQ:  if (bus_gnt) w_state_nxt = PREA;
            AREF: begin
                if (lTrfc > 1) begin
                    w_state_nxt = TRFC;
                    w_cnt_nxt   = 16'(lTrfc - 2);
                end else begin
                    w_state_nxt   = IDLE;
                    w_timer_clear = 1'b1;
                end
            end
            TRFC: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = IDLE;
                    w_timer_clear = 1'b1;
                end
            end
            default: w_state_nxt = INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd       <= CMD_NOP;
            r_ba        <= '0;
            r_a         <= '0;
            r_init_done <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_own   <= 1'b1;
        end else begin
            r_cmd <= CMD_NOP;
            r_ba  <= '0;
            r_a   <= '0;
            case (r_state)
                I_PREA, PREA: begin
                    r_cmd <= CMD_PRE;
                    r_a   <= lPreaAddr;
                end
                I_AREF, AREF: r_cmd <= CMD_AREF;
                I_LMR: begin
                    r_cmd <= CMD_LMR;
                    r_a   <= pModeValue;
                end
                default: ;
            endcase
            r_init_done <= r_init_done | (r_state == IDLE);
            r_bus_req   <= (r_state inside {REQ, PREA, TRP, AREF, TRFC});
            r_bus_own   <= !(r_state inside {IDLE, REQ});
        end
    end

    assign {cs_n, ras_n, cas_n, we_n} = r_cmd;
    assign ba        = r_ba;
    assign a         = r_a;
    assign init_done = r_init_done;
    assign bus_req   = r_bus_req;
    assign bus_own   = r_bus_own;

endmodule
